// File: rtl/pio_loader.sv
// pio_loader: configures one PIO state machine from an instruction ROM
// (INSTR x L, PEND, DIV, GRPS, SHIFT, EN), then streams bytes from a
// valid/ready source into its TX FIFO as PUSH actions.
// Optional RX path (PULL into a 1-entry buffer): define PIO_LOADER_RX_EN.
module pio_loader #(
  parameter int PLEN_MAX = 32,
  parameter int NUM_SM   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [1:0]        sm_sel,
  input  logic [5:0]        plen,
  input  logic [23:0]       div,
  input  logic [31:0]       pin_grps,
  input  logic [31:0]       exec_ctrl,
  input  logic [31:0]       shift_ctrl,
  output logic [4:0]        prog_addr,
  input  logic [15:0]       prog_data,
  output logic [3:0]        action,
  output logic [4:0]        index,
  output logic [1:0]        mindex,
  output logic [31:0]       din,
  input  logic [NUM_SM-1:0] full,
  input  logic [NUM_SM-1:0] empty,
  input  logic              tx_valid,
  input  logic [7:0]        tx_data,
  output logic              tx_ready,
  output logic              busy,
  output logic              running
`ifdef PIO_LOADER_RX_EN
  ,
  input  logic [31:0]       dout,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic [31:0]       rx_data
`endif
);

  localparam logic [3:0] A_NONE  = 4'd0;
  localparam logic [3:0] A_INSTR = 4'd1;
  localparam logic [3:0] A_PEND  = 4'd2;
  localparam logic [3:0] A_PUSH  = 4'd4;
  localparam logic [3:0] A_GRPS  = 4'd5;
  localparam logic [3:0] A_EN    = 4'd6;
  localparam logic [3:0] A_DIV   = 4'd7;
  localparam logic [3:0] A_SHIFT = 4'd10;
`ifdef PIO_LOADER_RX_EN
  localparam logic [3:0] A_PULL  = 4'd3;
`endif

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_INSTR, S_PEND, S_DIV, S_GRPS, S_SHIFT, S_EN, S_RUN, S_DIS
  } state_t;

  state_t      state, state_n;
  logic [5:0]  len_q, cnt_q, cnt_n, len_in;
  logic [23:0] div_q;
  logic [31:0] grps_q, exec_q, shift_q;
  logic [4:0]  addr_n, index_n;
  logic [3:0]  action_n;
  logic [1:0]  mindex_n;
  logic [31:0] din_n;
  logic        ready_n, busy_n, running_n, cfg_ld, push_go;

  // Program length is clamped to the instruction memory depth.
  assign len_in = (plen > 6'(PLEN_MAX)) ? 6'(PLEN_MAX) : plen;

`ifdef PIO_LOADER_RX_EN
  logic pull_d, pull_busy;
  assign pull_busy = (action == A_PULL) || pull_d;
`else
  logic unused_empty;
  assign unused_empty = ^empty;
`endif

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_n   = state;
    action_n  = A_NONE;
    din_n     = '0;
    index_n   = index;
    addr_n    = prog_addr;
    mindex_n  = mindex;
    cnt_n     = cnt_q;
    busy_n    = busy;
    running_n = running;
    ready_n   = 1'b0;
    cfg_ld    = 1'b0;
    push_go   = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        cfg_ld   = 1'b1;
        busy_n   = 1'b1;
        mindex_n = sm_sel;
        cnt_n    = '0;
        if (len_in == 6'd0) state_n = S_PEND;
        else begin
          addr_n  = '0;
          state_n = S_FETCH;
        end
      end
      // ROM read of address 0 is in flight; run the address one ahead.
      S_FETCH: begin
        if (6'd1 < len_q) addr_n = 5'd1;
        state_n = S_INSTR;
      end
      S_INSTR: begin
        action_n = A_INSTR;
        index_n  = cnt_q[4:0];
        din_n    = {16'h0, prog_data};
        if (6'(prog_addr) + 6'd1 < len_q) addr_n = prog_addr + 5'd1;
        cnt_n = cnt_q + 6'd1;
        if (cnt_q + 6'd1 == len_q) state_n = S_PEND;
      end
      S_PEND:  begin action_n = A_PEND;  din_n = exec_q;         state_n = S_DIV;   end
      S_DIV:   begin action_n = A_DIV;   din_n = {8'h0, div_q};  state_n = S_GRPS;  end
      S_GRPS:  begin action_n = A_GRPS;  din_n = grps_q;         state_n = S_SHIFT; end
      S_SHIFT: begin action_n = A_SHIFT; din_n = shift_q;        state_n = S_EN;    end
      S_EN:    begin action_n = A_EN;    din_n = 32'h1;          state_n = S_RUN;   end
      S_RUN: begin
        busy_n    = 1'b0;
        running_n = 1'b1;
        push_go   = tx_valid && tx_ready;
        if (push_go) begin
          action_n = A_PUSH;
          din_n    = {24'h0, tx_data};
        end
`ifdef PIO_LOADER_RX_EN
        else if (!stop && !rx_valid && !pull_busy && !empty[mindex])
          action_n = A_PULL;
`endif
        // Blocking the slot after a push gives the full flag time to update.
        if (stop) begin
          running_n = 1'b0;
          state_n   = S_DIS;
        end else
          ready_n = !full[mindex] && !push_go;
      end
      S_DIS: begin
        action_n = A_EN;
        state_n  = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt_q     <= '0;
      prog_addr <= '0;
      action    <= A_NONE;
      index     <= '0;
      mindex    <= '0;
      din       <= '0;
      tx_ready  <= 1'b0;
      busy      <= 1'b0;
      running   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt_q     <= cnt_n;
      prog_addr <= addr_n;
      action    <= action_n;
      index     <= index_n;
      mindex    <= mindex_n;
      din       <= din_n;
      tx_ready  <= ready_n;
      busy      <= busy_n;
      running   <= running_n;
    end
  end

  // Configuration words captured on an accepted start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_q   <= '0;
      div_q   <= '0;
      grps_q  <= '0;
      exec_q  <= '0;
      shift_q <= '0;
    end else if (cfg_ld) begin
      len_q   <= len_in;
      div_q   <= div;
      grps_q  <= pin_grps;
      exec_q  <= exec_ctrl;
      shift_q <= shift_ctrl;
    end
  end

`ifdef PIO_LOADER_RX_EN
  // RX buffer: dout lands the cycle after PULL, held until rx_ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pull_d   <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
    end else begin
      pull_d <= (action == A_PULL);
      if (pull_d) begin
        rx_valid <= 1'b1;
        rx_data  <= dout;
      end else if (rx_valid && rx_ready)
        rx_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_pio_loader.sv
// tb_pio_loader: directed stimulus, queue-based reference model of the
// action stream, per-cycle compare plus literal spot checks.
module tb_pio_loader;
  localparam logic [3:0] A_NONE = 4'd0, A_INSTR = 4'd1, A_PEND = 4'd2, A_PUSH = 4'd4,
                         A_GRPS = 4'd5, A_EN = 4'd6, A_DIV = 4'd7, A_SHIFT = 4'd10;

  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, stop = 1'b0;
  logic [1:0]  sm_sel = '0;
  logic [5:0]  plen = '0;
  logic [23:0] div = '0;
  logic [31:0] pin_grps = '0, exec_ctrl = '0, shift_ctrl = '0;
  logic [4:0]  prog_addr;
  logic [15:0] prog_data = '0;
  logic [3:0]  action;
  logic [4:0]  index;
  logic [1:0]  mindex;
  logic [31:0] din;
  logic [3:0]  full = '0, empty = '0;
  logic        tx_valid = 1'b0, tx_ready, busy, running;
  logic [7:0]  tx_data = '0;

  pio_loader dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .sm_sel(sm_sel), .plen(plen),
    .div(div), .pin_grps(pin_grps), .exec_ctrl(exec_ctrl), .shift_ctrl(shift_ctrl),
    .prog_addr(prog_addr), .prog_data(prog_data), .action(action), .index(index),
    .mindex(mindex), .din(din), .full(full), .empty(empty), .tx_valid(tx_valid),
    .tx_data(tx_data), .tx_ready(tx_ready), .busy(busy), .running(running)
  );

  always #5 clk = ~clk;

  // Instruction ROM: word i = 16'hC000 + i, one-cycle read latency.
  logic [15:0] rom [32];
  initial for (int i = 0; i < 32; i++) rom[i] = 16'hC000 + 16'(i);
  always @(posedge clk) prog_data <= rom[prog_addr];

  int total = 0, bad = 0;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: on start, the whole configuration stream is queued as
  // a list of (action, index, din); RUN applies the push/ready rules.
  typedef struct packed { logic [3:0] a; logic [4:0] i; logic [31:0] d; } item_t;
  item_t q[$];
  localparam int M_IDLE = 0, M_CFG = 1, M_RUN = 2, M_DIS = 3;
  int          mode;
  logic [3:0]  e_act;
  logic [4:0]  e_idx;
  logic [31:0] e_din;
  logic [1:0]  e_sel;
  logic        e_busy, e_run, e_ready;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mode <= M_IDLE; e_act <= A_NONE; e_idx <= '0; e_din <= '0; e_sel <= '0;
      e_busy <= 1'b0; e_run <= 1'b0; e_ready <= 1'b0;
      q.delete();
    end else begin
      e_act <= A_NONE;
      e_din <= '0;
      case (mode)
        M_IDLE: if (start) begin
          q.delete();
          if (plen != 0) begin
            q.push_back('{A_NONE, 5'd0, 32'd0});
            for (int i = 0; i < ((plen > 6'd32) ? 32 : int'(plen)); i++)
              q.push_back('{A_INSTR, 5'(i), {16'h0, rom[i]}});
          end
          q.push_back('{A_PEND,  5'd0, exec_ctrl});
          q.push_back('{A_DIV,   5'd0, {8'h0, div}});
          q.push_back('{A_GRPS,  5'd0, pin_grps});
          q.push_back('{A_SHIFT, 5'd0, shift_ctrl});
          q.push_back('{A_EN,    5'd0, 32'h1});
          e_sel <= sm_sel; e_busy <= 1'b1; mode <= M_CFG;
        end
        M_CFG: if (q.size() > 0) begin
          e_act <= q[0].a; e_idx <= q[0].i; e_din <= q[0].d;
          void'(q.pop_front());
        end else begin
          e_busy <= 1'b0; e_run <= 1'b1; e_ready <= !full[e_sel]; mode <= M_RUN;
        end
        M_RUN: begin
          if (tx_valid && e_ready) begin e_act <= A_PUSH; e_din <= {24'h0, tx_data}; end
          if (stop) begin e_ready <= 1'b0; e_run <= 1'b0; mode <= M_DIS; end
          else e_ready <= !full[e_sel] && !(tx_valid && e_ready);
        end
        default: begin e_act <= A_EN; e_din <= '0; mode <= M_IDLE; end
      endcase
    end
  end

  // Per-cycle compare against the model, plus push/instr bookkeeping.
  int cyc = 0, n_instr = 0;
  logic [4:0] max_idx = '0;
  int pcyc[$];
  logic [31:0] pdin[$];
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (!reset) begin
      chk("action", action, e_act);
      if (e_act != A_NONE) chk("din", din, e_din);
      if (e_act == A_INSTR) chk("index", index, e_idx);
      chk("busy", busy, e_busy);
      chk("running", running, e_run);
      chk("tx_ready", tx_ready, e_ready);
      chk("mindex", mindex, e_sel);
      chk("addr_range", prog_addr <= 5'd31, 1);
      if (action == A_INSTR) begin
        n_instr <= n_instr + 1;
        if (index > max_idx) max_idx <= index;
      end
      if (action == A_PUSH) begin pcyc.push_back(cyc); pdin.push_back(din); end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pulses start; returns at the negedge right after the start edge.
  task automatic do_start(input logic [5:0] l, input logic [1:0] sel);
    plen = l; sm_sel = sel;
    div = 24'h0200; pin_grps = 32'h40100000; exec_ctrl = 32'h40003000; shift_ctrl = 32'h00080000;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic do_stop;
    stop = 1'b1; tick(1); stop = 1'b0; tick(2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int bnd;
    tick(2);
    chk("rst_action", action, 0); chk("rst_din", din, 0); chk("rst_index", index, 0);
    chk("rst_mindex", mindex, 0); chk("rst_addr", prog_addr, 0); chk("rst_ready", tx_ready, 0);
    chk("rst_busy", busy, 0); chk("rst_running", running, 0);
    #1 reset = 1'b0;

    // plen=4 configuration, literal timing from the start edge
    tick(1);
    do_start(6'd4, 2'd0);
    chk("t1_busy", busy, 1);
    tick(2); chk("t1_i0_act", action, 1); chk("t1_i0_din", din, 32'h0000C000);
    tick(3); chk("t1_i3_idx", index, 3); chk("t1_i3_din", din, 32'h0000C003);
    tick(1); chk("t1_pend", action, 2); chk("t1_pend_din", din, 32'h40003000);
    tick(1); chk("t1_div", action, 7); chk("t1_div_din", din, 32'h00000200);
    tick(3); chk("t1_en", action, 6); chk("t1_en_din", din, 32'h1); chk("t1_run0", running, 0);
    tick(1); chk("t1_run11", running, 1); chk("t1_busy11", busy, 0); chk("t1_none", action, 0);

    // stream bytes 0x30..0x39 with valid held
    pcyc.delete(); pdin.delete();
    for (int b = 0; b < 10; b++) begin
      tx_data = 8'h30 + 8'(b); tx_valid = 1'b1;
      bnd = 0;
      while (!tx_ready && bnd < 50) begin tick(1); bnd++; end
      chk("tx_ready_wait", tx_ready, 1);
      tick(1);
    end
    tx_valid = 1'b0;
    tick(2);
    chk("push_count", pcyc.size(), 10);
    for (int k = 0; k < pcyc.size() && k < 10; k++) begin
      chk("push_din", pdin[k], 32'h30 + k);
      if (k > 0) chk("push_gap", pcyc[k] - pcyc[k-1], 2);
    end

    // TX full back-pressure
    full = 4'b0001; tick(1);
    tx_valid = 1'b1; tx_data = 8'h55;
    pcyc.delete();
    tick(19);
    chk("full_ready", tx_ready, 0); chk("full_nopush", pcyc.size(), 0);
    full = 4'b0000;
    tick(1); chk("unfull_ready", tx_ready, 1);
    tick(1); chk("unfull_push", action, 4); chk("unfull_din", din, 32'h55);
    tx_valid = 1'b0;
    tick(2);

    // stop with a push landing in the same cycle
    chk("pre_stop_ready", tx_ready, 1);
    stop = 1'b1; tx_valid = 1'b1; tx_data = 8'hA5;
    tick(1);
    stop = 1'b0; tx_valid = 1'b0;
    chk("stop_push", action, 4); chk("stop_push_din", din, 32'hA5);
    chk("stop_run", running, 0); chk("stop_ready", tx_ready, 0);
    tick(1); chk("dis_act", action, 6); chk("dis_din", din, 0);
    tick(1); chk("idle_act", action, 0);

    // plen=0 on machine 2: PEND first, ROM address untouched
    tick(1);
    do_start(6'd0, 2'd2);
    chk("p0_addr0", prog_addr, 3); chk("p0_act0", action, 0);
    tick(1); chk("p0_pend", action, 2); chk("p0_addr1", prog_addr, 3);
    tick(5); chk("p0_running", running, 1); chk("p0_mindex", mindex, 2);
    full = 4'b0100; tick(2); chk("p0_full2", tx_ready, 0);
    full = 4'b0001; tick(2); chk("p0_full0_ignored", tx_ready, 1);
    full = 4'b0000;
    start = 1'b1; tick(1); start = 1'b0;
    tick(1); chk("p0_start_ignored", running, 1);
    do_stop();

    // plen=40 clamps to 32 instructions
    n_instr = 0; max_idx = '0;
    do_start(6'd40, 2'd1);
    tick(41);
    chk("p40_count", n_instr, 32); chk("p40_maxidx", max_idx, 31); chk("p40_running", running, 1);
    do_stop();

    // reset in the middle of the instruction burst
    do_start(6'd4, 2'd3);
    tick(4); chk("mid_idx", index, 2); chk("mid_act", action, 1);
    #2 reset = 1'b1;
    #1;
    chk("ar_action", action, 0); chk("ar_index", index, 0); chk("ar_mindex", mindex, 0);
    chk("ar_din", din, 0); chk("ar_addr", prog_addr, 0); chk("ar_busy", busy, 0);
    tick(1);
    #1 reset = 1'b0;
    tick(1);
    do_start(6'd4, 2'd0);
    tick(2); chk("re_act", action, 1); chk("re_idx", index, 0); chk("re_din", din, 32'h0000C000);
    tick(9); chk("re_running", running, 1);
    do_stop();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
